// File: rtl/limb_pkg.sv
// Shared definitions for the limb CPU, its writable instruction memory and the program loader.
package limb_pkg;

   localparam int unsigned LIMB_ADDR_W  = 8;
   localparam int unsigned LIMB_INSTR_W = 32;
   localparam logic [7:0]  LOADER_MAGIC = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      WRITE,
      CHK
   } loader_state_t;

endpackage

// File: rtl/limb_loader.sv
// Program loader: receives a framed byte stream, assembles little-endian words into
// instruction memory while holding the CPU, then checks the frame checksum.
module limb_loader
   import limb_pkg::*;
#(
   parameter logic [7:0]  MAGIC  = LOADER_MAGIC,
   parameter int unsigned ADDR_W = LIMB_ADDR_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    prog_we,
   output logic [ADDR_W-1:0]       prog_addr,
   output logic [LIMB_INSTR_W-1:0] prog_data,
   output logic                    cpu_hold,
   output logic                    done,
   output logic                    error
);

   loader_state_t state;
   loader_state_t state_next;

   logic                    accept;
   logic [8:0]              word_cnt;
   logic [1:0]              idx;
   logic [LIMB_INSTR_W-1:0] shadow;
   logic [7:0]              checksum;
   logic [7:0]              sum_next;
   logic [ADDR_W-1:0]       addr;

   assign accept    = in_valid && in_ready;
   assign sum_next  = checksum + in_data;
   assign prog_addr = addr;
   assign prog_data = shadow;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // in_ready and prog_we are gated by reset so both read 0 while reset is held low
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      prog_we    = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = reset;
            if (accept && in_data == MAGIC) begin
               state_next = LEN;
            end
         end
         LEN: begin
            in_ready = reset;
            if (accept) begin
               state_next = DATA;
            end
         end
         DATA: begin
            in_ready = reset;
            if (accept && idx == 2'd3) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            prog_we    = reset;
            state_next = (word_cnt == 9'd1) ? CHK : DATA;
         end
         CHK: begin
            in_ready = reset;
            if (accept) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         word_cnt <= '0;
         idx      <= '0;
         shadow   <= '0;
         checksum <= '0;
         addr     <= '0;
         cpu_hold <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept && in_data == MAGIC) begin
                  cpu_hold <= 1'b1;
                  error    <= 1'b0;
                  checksum <= '0;
                  addr     <= '0;
               end
            end
            LEN: begin
               if (accept) begin
                  word_cnt <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                  idx      <= '0;
               end
            end
            DATA: begin
               if (accept) begin
                  shadow[{idx, 3'b000} +: 8] <= in_data;
                  checksum                   <= sum_next;
                  if (idx != 2'd3) begin
                     idx <= idx + 2'd1;
                  end
               end
            end
            WRITE: begin
               addr     <= addr + 1'b1;
               word_cnt <= word_cnt - 9'd1;
               idx      <= '0;
            end
            CHK: begin
               if (accept) begin
                  checksum <= sum_next;
                  if (sum_next == 8'h00) begin
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_limb_loader.sv
// Directed-vector bench for limb_loader: framing, checksum, length-0 loads, stalls and reset.
module tb_limb_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [31:0] prog_data;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   int unsigned done_count  = 0;
   logic        prev_we     = 1'b0;
   logic [7:0]  wq_addr[$];
   logic [31:0] wq_data[$];

   limb_loader #(.MAGIC(8'hA5), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Records every write and checks write-strobe properties once per cycle
   always @(posedge clk) begin
      #1;
      if (prog_we === 1'b1) begin
         wq_addr.push_back(prog_addr);
         wq_data.push_back(prog_data);
         vectors++;
         if (in_ready !== 1'b0) begin
            $display("FAIL we_ready got in_ready=%b want 0 during write", in_ready);
            miscompares++;
         end
         vectors++;
         if (prev_we !== 1'b0) begin
            $display("FAIL we_consecutive got prev prog_we=%b want 0", prev_we);
            miscompares++;
         end
      end
      if (done === 1'b1) done_count++;
      prev_we = prog_we;
   end

   task automatic send_byte(input logic [7:0] b);
      int unsigned waited = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready !== 1'b1) begin
         vectors++;
         $display("FAIL send_timeout byte %h got in_ready=%b want 1", b, in_ready);
         miscompares++;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got %b want 0", in_ready); miscompares++; end
      vectors++; if (prog_we !== 1'b0) begin $display("FAIL reset_prog_we got %b want 0", prog_we); miscompares++; end
      vectors++; if (prog_addr !== 8'h00) begin $display("FAIL reset_prog_addr got %h want 00", prog_addr); miscompares++; end
      vectors++; if (prog_data !== 32'h0) begin $display("FAIL reset_prog_data got %h want 0", prog_data); miscompares++; end
      vectors++; if (cpu_hold !== 1'b0) begin $display("FAIL reset_cpu_hold got %b want 0", cpu_hold); miscompares++; end
      vectors++; if (done !== 1'b0) begin $display("FAIL reset_done got %b want 0", done); miscompares++; end
      vectors++; if (error !== 1'b0) begin $display("FAIL reset_error got %b want 0", error); miscompares++; end
      reset = 1'b1;
      @(negedge clk);
      vectors++; if (in_ready !== 1'b1) begin $display("FAIL idle_in_ready got %b want 1", in_ready); miscompares++; end
   endtask

   task automatic test_single_word;
      int unsigned d0;
      logic [7:0] body[5] = '{8'h01, 8'h44, 8'h33, 8'h22, 8'h11};
      wq_addr.delete(); wq_data.delete();
      d0 = done_count;
      send_byte(8'hA5);
      vectors++; if (cpu_hold !== 1'b1) begin $display("FAIL sw_hold_after_magic got %b want 1", cpu_hold); miscompares++; end
      foreach (body[i]) send_byte(body[i]);
      vectors++; if (prog_we !== 1'b1) begin $display("FAIL sw_we_latency got %b want 1", prog_we); miscompares++; end
      vectors++; if (in_ready !== 1'b0) begin $display("FAIL sw_ready_in_write got %b want 0", in_ready); miscompares++; end
      vectors++; if (prog_addr !== 8'h00) begin $display("FAIL sw_addr got %h want 00", prog_addr); miscompares++; end
      vectors++; if (prog_data !== 32'h11223344) begin $display("FAIL sw_data got %h want 11223344", prog_data); miscompares++; end
      send_byte(8'h56);
      vectors++; if (done !== 1'b1) begin $display("FAIL sw_done got %b want 1", done); miscompares++; end
      vectors++; if (cpu_hold !== 1'b0) begin $display("FAIL sw_hold_release got %b want 0", cpu_hold); miscompares++; end
      vectors++; if (error !== 1'b0) begin $display("FAIL sw_error got %b want 0", error); miscompares++; end
      @(negedge clk);
      vectors++; if (done !== 1'b0) begin $display("FAIL sw_done_pulse got %b want 0", done); miscompares++; end
      vectors++; if (wq_addr.size() != 1) begin $display("FAIL sw_write_count got %0d want 1", wq_addr.size()); miscompares++; end
      vectors++; if (done_count - d0 != 1) begin $display("FAIL sw_done_count got %0d want 1", done_count - d0); miscompares++; end
   endtask

   task automatic test_bad_checksum;
      int unsigned d0;
      logic [7:0] bad[7]  = '{8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h57};
      logic [7:0] good[6] = '{8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h56};
      wq_addr.delete(); wq_data.delete();
      d0 = done_count;
      foreach (bad[i]) send_byte(bad[i]);
      @(negedge clk);
      vectors++; if (wq_addr.size() != 1) begin $display("FAIL bc_write_count got %0d want 1", wq_addr.size()); miscompares++; end
      else begin
         vectors++; if (wq_data[0] !== 32'h11223344) begin $display("FAIL bc_write_data got %h want 11223344", wq_data[0]); miscompares++; end
      end
      vectors++; if (error !== 1'b1) begin $display("FAIL bc_error got %b want 1", error); miscompares++; end
      vectors++; if (cpu_hold !== 1'b1) begin $display("FAIL bc_hold got %b want 1", cpu_hold); miscompares++; end
      vectors++; if (done_count != d0) begin $display("FAIL bc_no_done got %0d want 0", done_count - d0); miscompares++; end
      send_byte(8'hA5);
      vectors++; if (error !== 1'b0) begin $display("FAIL bc_error_clear got %b want 0", error); miscompares++; end
      foreach (good[i]) send_byte(good[i]);
      @(negedge clk);
      vectors++; if (cpu_hold !== 1'b0) begin $display("FAIL bc_recover_hold got %b want 0", cpu_hold); miscompares++; end
      vectors++; if (done_count - d0 != 1) begin $display("FAIL bc_recover_done got %0d want 1", done_count - d0); miscompares++; end
   endtask

   task automatic test_garbage;
      int unsigned d0;
      wq_addr.delete(); wq_data.delete();
      d0 = done_count;
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      vectors++; if (cpu_hold !== 1'b0) begin $display("FAIL gb_hold_before_magic got %b want 0", cpu_hold); miscompares++; end
      send_byte(8'hA5); send_byte(8'h02);
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      send_byte(8'hDC);
      @(negedge clk);
      vectors++; if (wq_addr.size() != 2) begin $display("FAIL gb_write_count got %0d want 2", wq_addr.size()); miscompares++; end
      else begin
         vectors++; if (wq_addr[0] !== 8'h00 || wq_data[0] !== 32'h04030201) begin $display("FAIL gb_word0 got %h:%h want 00:04030201", wq_addr[0], wq_data[0]); miscompares++; end
         vectors++; if (wq_addr[1] !== 8'h01 || wq_data[1] !== 32'h08070605) begin $display("FAIL gb_word1 got %h:%h want 01:08070605", wq_addr[1], wq_data[1]); miscompares++; end
      end
      vectors++; if (done_count - d0 != 1) begin $display("FAIL gb_done got %0d want 1", done_count - d0); miscompares++; end
      vectors++; if (error !== 1'b0) begin $display("FAIL gb_error got %b want 0", error); miscompares++; end
   endtask

   task automatic test_len_zero;
      int unsigned d0;
      wq_addr.delete(); wq_data.delete();
      d0 = done_count;
      send_byte(8'hA5); send_byte(8'h00);
      for (int i = 0; i < 1024; i++) send_byte(8'h00);
      send_byte(8'h00);
      @(negedge clk);
      vectors++; if (wq_addr.size() != 256) begin $display("FAIL lz_write_count got %0d want 256", wq_addr.size()); miscompares++; end
      else begin
         for (int i = 0; i < 256; i++) begin
            vectors++;
            if (wq_addr[i] !== 8'(i) || wq_data[i] !== 32'h0) begin
               $display("FAIL lz_write_%0d got %h:%h want %h:00000000", i, wq_addr[i], wq_data[i], 8'(i));
               miscompares++;
            end
         end
      end
      vectors++; if (done_count - d0 != 1) begin $display("FAIL lz_done got %0d want 1", done_count - d0); miscompares++; end
      vectors++; if (cpu_hold !== 1'b0) begin $display("FAIL lz_hold got %b want 0", cpu_hold); miscompares++; end
   endtask

   task automatic test_stalls;
      int unsigned d0;
      logic [7:0] frame[7] = '{8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h56};
      wq_addr.delete(); wq_data.delete();
      d0 = done_count;
      foreach (frame[i]) begin
         idle($urandom_range(0, 3));
         send_byte(frame[i]);
      end
      idle(2);
      vectors++; if (wq_addr.size() != 1) begin $display("FAIL st_write_count got %0d want 1", wq_addr.size()); miscompares++; end
      else begin
         vectors++; if (wq_addr[0] !== 8'h00 || wq_data[0] !== 32'h11223344) begin $display("FAIL st_word got %h:%h want 00:11223344", wq_addr[0], wq_data[0]); miscompares++; end
      end
      vectors++; if (done_count - d0 != 1) begin $display("FAIL st_done got %0d want 1", done_count - d0); miscompares++; end
      vectors++; if (error !== 1'b0 || cpu_hold !== 1'b0) begin $display("FAIL st_flags got error=%b hold=%b want 0 0", error, cpu_hold); miscompares++; end
   endtask

   task automatic test_reset_mid_load;
      int unsigned d0;
      wq_addr.delete(); wq_data.delete();
      d0 = done_count;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h44); send_byte(8'h33);
      vectors++; if (cpu_hold !== 1'b1) begin $display("FAIL rm_hold_loading got %b want 1", cpu_hold); miscompares++; end
      reset = 1'b0;
      @(negedge clk);
      vectors++; if (in_ready !== 1'b0 || prog_we !== 1'b0) begin $display("FAIL rm_handshake got ready=%b we=%b want 0 0", in_ready, prog_we); miscompares++; end
      vectors++; if (prog_addr !== 8'h00 || prog_data !== 32'h0) begin $display("FAIL rm_prog got %h:%h want 00:00000000", prog_addr, prog_data); miscompares++; end
      vectors++; if (cpu_hold !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin $display("FAIL rm_flags got hold=%b done=%b error=%b want 0 0 0", cpu_hold, done, error); miscompares++; end
      reset = 1'b1;
      send_byte(8'h22); send_byte(8'h11);
      idle(4);
      vectors++; if (wq_addr.size() != 0) begin $display("FAIL rm_no_write got %0d want 0", wq_addr.size()); miscompares++; end
      vectors++; if (cpu_hold !== 1'b0) begin $display("FAIL rm_hold_after got %b want 0", cpu_hold); miscompares++; end
      vectors++; if (done_count != d0) begin $display("FAIL rm_no_done got %0d want 0", done_count - d0); miscompares++; end
   endtask

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(negedge clk);
      test_reset();
      test_single_word();
      test_bad_checksum();
      test_garbage();
      test_len_zero();
      test_stalls();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
